// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_pack_n lane packer.
package demux_pkg;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_AUTO     = 1'b1;

    // Bit offset of lane k inside a packed frame of w-bit lanes.
    function automatic int lane_offset(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/lane_ptr_ctr.sv
// Wrap-around lane pointer: counts 0..MODULUS-1 with enable and synchronous clear.
module lane_ptr_ctr #(
    parameter int MODULUS = 4,
    parameter int CNT_W   = 2
) (
    input  logic             inClock,
    input  logic             inReset,
    input  logic             inEnable,
    input  logic             inClear,
    output logic [CNT_W-1:0] outCount
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            r_cnt <= '0;
        end else if (inClear) begin
            r_cnt <= '0;
        end else if (inEnable) begin
            if (r_cnt == CNT_W'(MODULUS - 1)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign outCount = r_cnt;

endmodule

// File: rtl/demux_pack_n.sv
// Registered 1-to-N demultiplexer that packs lane writes into N*W-bit frames.
module demux_pack_n
    import demux_pkg::*;
#(
    parameter  int N_LANES = 4,
    parameter  int DATA_W  = 4,
    localparam int SEL_W   = $clog2(N_LANES)
) (
    input  logic                        inClock,
    input  logic                        inReset,
    input  logic                        inValid,
    input  logic [DATA_W-1:0]           inData,
    input  logic [SEL_W-1:0]            inSel,
    input  logic                        inMode,
    input  logic                        inClear,
    output logic [N_LANES*DATA_W-1:0]   outData,
    output logic [N_LANES-1:0]          outLaneValid,
    output logic [N_LANES*DATA_W-1:0]   outFrame,
    output logic                        outFrameValid,
    output logic                        outOverwrite
);

    logic [N_LANES*DATA_W-1:0] r_data;
    logic [N_LANES*DATA_W-1:0] r_frame;
    logic [N_LANES-1:0]        r_lane_valid;
    logic                      r_frame_valid;
    logic                      r_overwrite;
    logic                      r_prev_mode;

    logic [SEL_W-1:0]          w_ptr;
    logic [SEL_W-1:0]          w_target;
    logic                      w_in_range;
    logic                      w_flush;
    logic                      w_write;
    logic [N_LANES-1:0]        w_onehot;
    logic [N_LANES-1:0]        w_lane_valid_nxt;
    logic [N_LANES*DATA_W-1:0] w_data_nxt;
    logic                      w_hit_valid;
    logic                      w_complete;

    // A mode change flushes the partial frame exactly like inClear.
    assign w_flush    = inClear || (inMode != r_prev_mode);
    assign w_target   = (inMode == MODE_AUTO) ? w_ptr : inSel;
    assign w_in_range = ({1'b0, w_target} < (SEL_W + 1)'(N_LANES));
    assign w_write    = inValid && !w_flush && w_in_range;

    always_comb begin
        w_onehot   = '0;
        w_data_nxt = r_data;
        for (int k = 0; k < N_LANES; k++) begin
            if (w_write && (w_target == SEL_W'(k))) begin
                w_onehot[k] = 1'b1;
                w_data_nxt[lane_offset(k, DATA_W) +: DATA_W] = inData;
            end
        end
    end

    assign w_lane_valid_nxt = r_lane_valid | w_onehot;
    assign w_hit_valid      = |(r_lane_valid & w_onehot);
    assign w_complete       = &w_lane_valid_nxt;

    lane_ptr_ctr #(
        .MODULUS (N_LANES),
        .CNT_W   (SEL_W)
    ) u_ptr (
        .inClock  (inClock),
        .inReset  (inReset),
        .inEnable (w_write && (inMode == MODE_AUTO)),
        .inClear  (w_flush),
        .outCount (w_ptr)
    );

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            r_data        <= '0;
            r_frame       <= '0;
            r_lane_valid  <= '0;
            r_frame_valid <= 1'b0;
            r_overwrite   <= 1'b0;
            r_prev_mode   <= 1'b0;
        end else begin
            r_prev_mode   <= inMode;
            r_frame_valid <= 1'b0;
            r_overwrite   <= 1'b0;
            if (w_flush) begin
                r_lane_valid <= '0;
            end else if (w_write) begin
                r_data      <= w_data_nxt;
                r_overwrite <= w_hit_valid;
                if (w_complete) begin
                    r_frame       <= w_data_nxt;
                    r_frame_valid <= 1'b1;
                    r_lane_valid  <= '0;
                end else begin
                    r_lane_valid <= w_lane_valid_nxt;
                end
            end
        end
    end

    assign outData       = r_data;
    assign outLaneValid  = r_lane_valid;
    assign outFrame      = r_frame;
    assign outFrameValid = r_frame_valid;
    assign outOverwrite  = r_overwrite;

endmodule

// File: tb/tb_demux_pack_n.sv
// Directed bench for demux_pack_n with N_LANES=4, DATA_W=4.
module tb_demux_pack_n;

    logic        inClock = 1'b0;
    logic        inReset = 1'b0;
    logic        inValid = 1'b0;
    logic [3:0]  inData  = '0;
    logic [1:0]  inSel   = '0;
    logic        inMode  = 1'b0;
    logic        inClear = 1'b0;
    logic [15:0] outData;
    logic [3:0]  outLaneValid;
    logic [15:0] outFrame;
    logic        outFrameValid;
    logic        outOverwrite;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 inClock = ~inClock;

    demux_pack_n #(.N_LANES(4), .DATA_W(4)) dut (
        .inClock       (inClock),
        .inReset       (inReset),
        .inValid       (inValid),
        .inData        (inData),
        .inSel         (inSel),
        .inMode        (inMode),
        .inClear       (inClear),
        .outData       (outData),
        .outLaneValid  (outLaneValid),
        .outFrame      (outFrame),
        .outFrameValid (outFrameValid),
        .outOverwrite  (outOverwrite)
    );

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] s,
                         input logic m, input logic c);
        inValid = v; inData = d; inSel = s; inMode = m; inClear = c;
        @(posedge inClock);
        #1;
    endtask

    task automatic test_reset;
        inReset = 1'b0;
        repeat (5) drive(1'b1, 4'hF, 2'd3, 1'b1, 1'b0);
        inReset = 1'b1;
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (outData !== 16'h0000) begin n_bad++; $display("FAIL rst_data got %h exp %h", outData, 16'h0000); end
        n_cmp++; if (outLaneValid !== 4'b0000) begin n_bad++; $display("FAIL rst_lv got %b exp %b", outLaneValid, 4'b0000); end
        n_cmp++; if (outFrame !== 16'h0000) begin n_bad++; $display("FAIL rst_frame got %h exp %h", outFrame, 16'h0000); end
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL rst_fv got %b exp 0", outFrameValid); end
        n_cmp++; if (outOverwrite !== 1'b0) begin n_bad++; $display("FAIL rst_ow got %b exp 0", outOverwrite); end
    endtask

    task automatic test_auto_frame;
        logic [3:0] exp_lv [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b0000};
        drive(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 1), 2'd0, 1'b1, 1'b0);
            n_cmp++; if (outLaneValid !== exp_lv[i]) begin n_bad++; $display("FAIL auto_lv[%0d] got %b exp %b", i, outLaneValid, exp_lv[i]); end
            n_cmp++; if (outFrameValid !== (i == 3)) begin n_bad++; $display("FAIL auto_fv[%0d] got %b exp %b", i, outFrameValid, (i == 3)); end
        end
        n_cmp++; if (outFrame !== 16'h4321) begin n_bad++; $display("FAIL auto_frame got %h exp %h", outFrame, 16'h4321); end
        n_cmp++; if (outData !== 16'h4321) begin n_bad++; $display("FAIL auto_data got %h exp %h", outData, 16'h4321); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 4'h5, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0001) begin n_bad++; $display("FAIL b2b_lv got %b exp %b", outLaneValid, 4'b0001); end
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL b2b_fv_drop got %b exp 0", outFrameValid); end
        n_cmp++; if (outData !== 16'h4325) begin n_bad++; $display("FAIL b2b_data got %h exp %h", outData, 16'h4325); end
        drive(1'b1, 4'h6, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 4'h7, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 4'h8, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outFrameValid !== 1'b1) begin n_bad++; $display("FAIL b2b_fv got %b exp 1", outFrameValid); end
        n_cmp++; if (outFrame !== 16'h8765) begin n_bad++; $display("FAIL b2b_frame got %h exp %h", outFrame, 16'h8765); end
        drive(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_fv got %b exp 0", outFrameValid); end
    endtask

    task automatic test_explicit_frame;
        logic [1:0] sel    [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
        logic [3:0] dat    [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [3:0] exp_lv [4] = '{4'b1000, 4'b1010, 4'b1011, 4'b0000};
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dat[i], sel[i], 1'b0, 1'b0);
            n_cmp++; if (outLaneValid !== exp_lv[i]) begin n_bad++; $display("FAIL expl_lv[%0d] got %b exp %b", i, outLaneValid, exp_lv[i]); end
            n_cmp++; if (outFrameValid !== (i == 3)) begin n_bad++; $display("FAIL expl_fv[%0d] got %b exp %b", i, outFrameValid, (i == 3)); end
        end
        n_cmp++; if (outFrame !== 16'hADBC) begin n_bad++; $display("FAIL expl_frame got %h exp %h", outFrame, 16'hADBC); end
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL expl_idle_fv got %b exp 0", outFrameValid); end
    endtask

    task automatic test_overwrite;
        drive(1'b1, 4'h5, 2'd2, 1'b0, 1'b0);
        n_cmp++; if (outOverwrite !== 1'b0) begin n_bad++; $display("FAIL ow_first got %b exp 0", outOverwrite); end
        drive(1'b1, 4'h6, 2'd2, 1'b0, 1'b0);
        n_cmp++; if (outOverwrite !== 1'b1) begin n_bad++; $display("FAIL ow_pulse got %b exp 1", outOverwrite); end
        n_cmp++; if (outData[11:8] !== 4'h6) begin n_bad++; $display("FAIL ow_lane2 got %h exp %h", outData[11:8], 4'h6); end
        n_cmp++; if (outData !== 16'hA6BC) begin n_bad++; $display("FAIL ow_data got %h exp %h", outData, 16'hA6BC); end
        n_cmp++; if (outLaneValid !== 4'b0100) begin n_bad++; $display("FAIL ow_lv got %b exp %b", outLaneValid, 4'b0100); end
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL ow_fv got %b exp 0", outFrameValid); end
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (outOverwrite !== 1'b0) begin n_bad++; $display("FAIL ow_idle got %b exp 0", outOverwrite); end
    endtask

    task automatic test_clear;
        drive(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0000) begin n_bad++; $display("FAIL modechg_lv got %b exp %b", outLaneValid, 4'b0000); end
        drive(1'b1, 4'h1, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 4'h2, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0011) begin n_bad++; $display("FAIL clr_pre_lv got %b exp %b", outLaneValid, 4'b0011); end
        drive(1'b1, 4'hF, 2'd0, 1'b1, 1'b1);
        n_cmp++; if (outLaneValid !== 4'b0000) begin n_bad++; $display("FAIL clr_lv got %b exp %b", outLaneValid, 4'b0000); end
        n_cmp++; if (outData !== 16'hA621) begin n_bad++; $display("FAIL clr_data got %h exp %h", outData, 16'hA621); end
        n_cmp++; if (outFrame !== 16'hADBC) begin n_bad++; $display("FAIL clr_frame got %h exp %h", outFrame, 16'hADBC); end
        drive(1'b1, 4'h9, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0001) begin n_bad++; $display("FAIL clr_next_lv got %b exp %b", outLaneValid, 4'b0001); end
        n_cmp++; if (outData !== 16'hA629) begin n_bad++; $display("FAIL clr_next_data got %h exp %h", outData, 16'hA629); end
    endtask

    task automatic test_mode_reset;
        drive(1'b0, 4'h0, 2'd0, 1'b1, 1'b1);
        drive(1'b1, 4'h1, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 4'h2, 2'd0, 1'b1, 1'b0);
        drive(1'b1, 4'h3, 2'd0, 1'b1, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0111) begin n_bad++; $display("FAIL mode_pre_lv got %b exp %b", outLaneValid, 4'b0111); end
        // Toggle to explicit with a write that would otherwise complete the frame.
        drive(1'b1, 4'h5, 2'd3, 1'b0, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0000) begin n_bad++; $display("FAIL mode_lv got %b exp %b", outLaneValid, 4'b0000); end
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL mode_fv got %b exp 0", outFrameValid); end
        n_cmp++; if (outData !== 16'hA321) begin n_bad++; $display("FAIL mode_data got %h exp %h", outData, 16'hA321); end
        drive(1'b1, 4'h7, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0001) begin n_bad++; $display("FAIL mode_next_lv got %b exp %b", outLaneValid, 4'b0001); end
        inReset = 1'b0;
        drive(1'b1, 4'h8, 2'd1, 1'b0, 1'b0);
        n_cmp++; if (outData !== 16'h0000) begin n_bad++; $display("FAIL midrst_data got %h exp %h", outData, 16'h0000); end
        n_cmp++; if (outLaneValid !== 4'b0000) begin n_bad++; $display("FAIL midrst_lv got %b exp %b", outLaneValid, 4'b0000); end
        n_cmp++; if (outFrame !== 16'h0000) begin n_bad++; $display("FAIL midrst_frame got %h exp %h", outFrame, 16'h0000); end
        n_cmp++; if (outFrameValid !== 1'b0) begin n_bad++; $display("FAIL midrst_fv got %b exp 0", outFrameValid); end
        inReset = 1'b1;
        drive(1'b0, 4'h0, 2'd0, 1'b0, 1'b0);
        n_cmp++; if (outLaneValid !== 4'b0000) begin n_bad++; $display("FAIL postrst_lv got %b exp %b", outLaneValid, 4'b0000); end
    endtask

    initial begin
        test_reset();
        test_auto_frame();
        test_back_to_back();
        test_explicit_frame();
        test_overwrite();
        test_clear();
        test_mode_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/demux_pack_n.md
Name: demux_pack_n

Overview:
Parametrised registered 1-to-N demultiplexer and frame packer for the Zigbee datapath. It is the successor of the fixed 1-to-4 / 4-bit MUXN/DEMUX. It steers W-bit input words into N lane registers, either by explicit select or by an internal round-robin pointer. When every lane has been written, it emits the packed N*W-bit frame with a one-cycle strobe. It also adds per-lane valid tracking, overwrite detection, clear and mode-change handling.

Parameters:
N_LANES, 4, number of output lanes; legal range is 2 or more.
DATA_W, 4, width of one input word and one lane.
SEL_W, $clog2(N_LANES), derived localparam, not overridable; lane index width.

Ports:
inClock  input  1  system clock; all state updates on its rising edge.
inReset  input  1  synchronous active-low reset.
inValid  input  1  write strobe; inData is accepted on any rising edge where inValid=1.
inData  input  DATA_W  input word.
inSel  input  SEL_W  target lane in explicit mode; ignored in auto mode.
inMode  input  1  0 = explicit select, 1 = auto round-robin.
inClear  input  1  synchronous flush of the partial frame.
outData  output  N_LANES*DATA_W  live lane registers; lane k occupies bits [k*DATA_W +: DATA_W], so lane 0 is the LSBs.
outLaneValid  output  N_LANES  bit k=1 means lane k has been written in the current frame.
outFrame  output  N_LANES*DATA_W  snapshot of the last completed frame.
outFrameValid  output  1  one-cycle pulse when outFrame is updated.
outOverwrite  output  1  one-cycle pulse when a write targets a lane already valid.

Behaviour:
- Reset (inReset=0 at a rising edge): every output, all lane registers, the pointer and the stored previous mode go to 0. Reset overrides all other inputs.
- Write target: inSel in explicit mode; the pointer in auto mode. An inSel value of N_LANES or more, when N_LANES is not a power of 2, is dropped with no state change.
- Accepted write to lane k at edge t:
  - lane k takes inData and outLaneValid[k] goes to 1, both visible after edge t. Latency is 1 cycle.
  - In auto mode the pointer increments and wraps from N_LANES-1 to 0.
- Overwrite: writing a lane whose outLaneValid bit is already 1 updates the data and pulses outOverwrite for the cycle after the edge. It does not complete a frame on its own.
- Frame completion: when the write at edge t makes all outLaneValid bits 1 (computed from the next-state value), then at edge t:
  - outFrame takes the next-state packed data, including the word just written.
  - outFrameValid=1 for exactly the cycle after t.
  - outLaneValid clears to 0.
  - In auto mode the pointer is 0 after the wrap.
  - outData keeps the lane values until they are overwritten.
- inClear=1: outLaneValid and the pointer go to 0. outData and outFrame are kept. Any write in the same cycle is dropped. No frame or overwrite pulse is produced.
- Mode change: inMode is registered every cycle. A cycle where inMode differs from the stored previous mode behaves exactly as inClear, and the write in that cycle is dropped.
- Idle (inValid=0): state holds and both pulse outputs are 0.
- Back-to-back frames: a write in the cycle right after completion starts the new frame at lane 0 in auto mode. outFrameValid may therefore pulse every N_LANES cycles.

Decomposition:
- Package demux_pkg holds:
  - mode encoding constants MODE_EXPLICIT=1'b0 and MODE_AUTO=1'b1;
  - a helper function returning the lane slice offset, k*DATA_W.
- One natural sub-module, lane_ptr_ctr: a wrap-around counter with enable and synchronous clear, sized SEL_W with modulus N_LANES, used for auto mode.
- Lane storage and frame logic stay in the top level.

Test Plan (N_LANES=4, DATA_W=4):
1. Reset held 5 cycles, then released with all inputs 0 -> every output 0, including outData=16'h0000 and outLaneValid=4'b0000.
2. Auto mode, writes 1, 2, 3, 4 on consecutive cycles -> outLaneValid steps 0001, 0011, 0111. After the 4th edge: outFrame=16'h4321, outFrameValid=1 for one cycle, outLaneValid=0000.
3. Explicit mode, writes lane3=A, lane1=B, lane0=C, lane2=D -> outFrame=16'hADBC with a single outFrameValid pulse.
4. Explicit mode, lane 2 written 5 then 6 -> outOverwrite pulses once on the second write, outData[11:8]=6, outLaneValid=0100, no frame pulse.
5. Auto mode, two words written, then inClear asserted together with inValid -> that write dropped, outLaneValid=0000, next write lands in lane 0.
6. Auto mode, three words written, then inMode toggled -> partial frame flushed. Reset pulsed mid-frame -> all outputs 0 on the next cycle and no outFrameValid pulse.
